// File: rtl/fgen_dds_burst.sv
// rtl/fgen_dds_burst.sv - Phase-accumulator square-wave source with whole-period burst control.
// Ux is the registered accumulator MSB; a run always ends on a carry with the accumulator cleared.
module fgen_dds_burst #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             st,
  input  logic             ce,
  input  logic             load,
  input  logic [ACC_W-1:0] fcode,
  input  logic [CNT_W-1:0] nper,
  input  logic             stop,
  output logic             Ux,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] ncnt
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] fcode_q, fcode_d;
  logic [CNT_W-1:0] nper_q, nper_d;
  logic [CNT_W-1:0] ncnt_q, ncnt_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             stop_req_q, stop_req_d;

  logic [ACC_W:0]   sum;
  logic [CNT_W-1:0] ncnt_inc;
  logic             fcode_ok;

  always_ff @(posedge clk or posedge st) begin
    if (st) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      fcode_q    <= '0;
      nper_q     <= '0;
      ncnt_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      stop_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      fcode_q    <= fcode_d;
      nper_q     <= nper_d;
      ncnt_q     <= ncnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      stop_req_q <= stop_req_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    fcode_d    = fcode_q;
    nper_d     = nper_q;
    ncnt_d     = ncnt_q;
    err_d      = err_q;
    done_d     = 1'b0;
    stop_req_d = stop_req_q;

    sum      = {1'b0, acc_q} + {1'b0, fcode_q};
    ncnt_inc = (ncnt_q == {CNT_W{1'b1}}) ? ncnt_q : ncnt_q + 1'b1;
    // Codes at or above half the clock rate cannot produce a valid square wave.
    fcode_ok = (fcode != '0) && !fcode[ACC_W-1];

    case (state_q)
      S_IDLE: begin
        if (load) begin
          if (fcode_ok) begin
            fcode_d    = fcode;
            nper_d     = nper;
            acc_d      = '0;
            ncnt_d     = '0;
            err_d      = 1'b0;
            stop_req_d = 1'b0;
            state_d    = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (stop) stop_req_d = 1'b1;
        if (ce) begin
          acc_d = sum[ACC_W-1:0];
          if (sum[ACC_W]) begin
            ncnt_d = ncnt_inc;
            if (((nper_q != '0) && (ncnt_inc == nper_q)) || stop_req_q) begin
              acc_d      = '0;
              state_d    = S_IDLE;
              done_d     = 1'b1;
              stop_req_d = 1'b0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Ux   = acc_q[ACC_W-1];
  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign err  = err_q;
  assign ncnt = ncnt_q;

endmodule

// File: tb/tb_fgen_dds_burst.sv
// tb/tb_fgen_dds_burst.sv - Directed bench for fgen_dds_burst with a done-event scoreboard.
module tb_fgen_dds_burst;

  localparam int ACC_W = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             st = 1'b1;
  logic             ce = 1'b1;
  logic             load = 1'b0;
  logic [ACC_W-1:0] fcode = '0;
  logic [CNT_W-1:0] nper = '0;
  logic             stop = 1'b0;
  logic             Ux, busy, done, err;
  logic [CNT_W-1:0] ncnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0;

  typedef struct {
    int cyc;
    int ncnt;
  } exp_t;
  exp_t sb[$];

  fgen_dds_burst #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .st(st), .ce(ce), .load(load), .fcode(fcode), .nper(nper),
    .stop(stop), .Ux(Ux), .busy(busy), .done(done), .err(err), .ncnt(ncnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_done(input int dcyc, input int dn);
    exp_t e;
    e.cyc  = dcyc;
    e.ncnt = dn;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!st && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", done, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_ncnt", ncnt, e.ncnt);
        chk("done_ux", Ux, 0);
        chk("done_busy", busy, 0);
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_ux", Ux, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ncnt", ncnt, 0);
    st = 1'b0;
    tick();

    // Stop in IDLE is ignored
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("idle_stop_busy", busy, 0);

    // Burst of 3 periods at fcode=64
    load = 1'b1; fcode = 8'd64; nper = 16'd3;
    tick();
    load = 1'b0;
    c0 = cyc;
    push_done(c0 + 12, 3);
    chk("b3_busy", busy, 1);
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("b3_ux", Ux, ((k * 64) % 256) / 128);
      chk("b3_ncnt", ncnt, k / 4);
    end
    tick();
    chk("b3_end_busy", busy, 0);
    chk("b3_end_done", done, 1);
    chk("b3_end_ncnt", ncnt, 3);
    repeat (3) tick();
    chk("b3_hold_ncnt", ncnt, 3);
    chk("b3_hold_done", done, 0);

    // Continuous run, stop seen after clock 6, ends on the carry at clock 8
    load = 1'b1; fcode = 8'd96; nper = 16'd0;
    tick();
    load = 1'b0;
    c0 = cyc;
    push_done(c0 + 8, 3);
    repeat (6) tick();
    chk("cont_ncnt6", ncnt, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("cont_still_busy", busy, 1);
    tick();
    chk("cont_end_busy", busy, 0);
    chk("cont_end_ncnt", ncnt, 3);
    tick();

    // Clock-enable gating: enabled on every other cycle
    load = 1'b1; fcode = 8'd64; nper = 16'd1;
    tick();
    load = 1'b0;
    c0 = cyc;
    push_done(c0 + 8, 1);
    for (int k = 1; k <= 8; k++) begin
      ce = (k % 2 == 0);
      tick();
      if (k < 8) chk("ce_ux", Ux, ((64 * (k / 2)) % 256) / 128);
    end
    ce = 1'b1;
    chk("ce_end_busy", busy, 0);
    tick();

    // Rejected loads, then a valid one; load during RUN is ignored
    load = 1'b1; fcode = 8'd0; nper = 16'd1;
    tick();
    chk("rej0_err", err, 1);
    chk("rej0_busy", busy, 0);
    fcode = 8'd128;
    tick();
    chk("rej128_err", err, 1);
    chk("rej128_busy", busy, 0);
    fcode = 8'd32;
    tick();
    c0 = cyc;
    push_done(c0 + 8, 1);
    chk("ok_err", err, 0);
    chk("ok_busy", busy, 1);
    fcode = 8'd0;
    tick();
    load = 1'b0;
    chk("run_load_err", err, 0);
    chk("run_load_busy", busy, 1);
    repeat (7) tick();
    chk("ok_end_busy", busy, 0);
    tick();

    // Stop held across the terminating carry: a single done
    load = 1'b1; fcode = 8'd64; nper = 16'd2;
    tick();
    load = 1'b0;
    c0 = cyc;
    push_done(c0 + 8, 2);
    repeat (6) tick();
    stop = 1'b1;
    repeat (2) tick();
    stop = 1'b0;
    chk("both_end_busy", busy, 0);
    repeat (3) tick();

    // Asynchronous reset mid-burst, then a clean restart
    load = 1'b1; fcode = 8'd64; nper = 16'd5;
    tick();
    load = 1'b0;
    repeat (7) tick();
    chk("pre_rst_ux", Ux, 1);
    chk("pre_rst_ncnt", ncnt, 1);
    st = 1'b1;
    #1;
    chk("mid_rst_ux", Ux, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ncnt", ncnt, 0);
    chk("mid_rst_done", done, 0);
    tick();
    st = 1'b0;
    tick();
    load = 1'b1; fcode = 8'd64; nper = 16'd1;
    tick();
    load = 1'b0;
    c0 = cyc;
    push_done(c0 + 4, 1);
    chk("restart_busy", busy, 1);
    repeat (4) tick();
    chk("restart_end_busy", busy, 0);
    repeat (3) tick();

    chk("pending_done", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fgen_dds_burst.md
Name: fgen_dds_burst

Overview:
- Phase-accumulator test-signal generator. It is the source end of the reciprocal frequency meter chain and drives the Ux input of the meter.
- Produces a square wave of frequency Fce*fcode/2^ACC_W.
- Runs either continuously or for an exact burst of nper whole periods, then reports completion.
- Lets the bench and board self-test the meter against a known frequency and a known X count.

Parameters:
ACC_W, 32, phase accumulator width; also the width of fcode.
CNT_W, 16, width of the period counter and of nper.

Ports:
clk  in  1  system clock (same clock as the meter's Tce domain).
st  in  1  reset, asynchronous, active-high; clears all state.
ce  in  1  clock enable; the accumulator advances only on cycles with ce=1.
load  in  1  start strobe, sampled in IDLE only.
fcode  in  ACC_W  frequency code, captured on an accepted load.
nper  in  CNT_W  burst length in periods; 0 = continuous, captured on load.
stop  in  1  graceful stop request.
Ux  out  1  generated signal, equal to acc[ACC_W-1] (registered).
busy  out  1  high while in RUN.
done  out  1  one-cycle pulse when a run ends.
err  out  1  sticky flag: last load was rejected.
ncnt  out  CNT_W  completed periods in the current or last run.

Behaviour:
- Reset (st=1, asynchronous):
  - state=IDLE; acc, fcode_r, nper_r, ncnt all 0.
  - Ux=0, busy=0, done=0, err=0, stop_req=0.
  - Applies immediately, including mid-run; no done pulse is generated.
- State IDLE:
  - load=1 with fcode!=0 and fcode[ACC_W-1]=0: latch fcode_r and nper_r; acc<=0, ncnt<=0, err<=0, stop_req<=0; go to RUN. busy=1 from the next cycle.
  - load=1 with fcode=0 or fcode[ACC_W-1]=1 (at or above Fce/2): reject. err<=1, stay in IDLE, no done pulse.
  - stop in IDLE is ignored.
- State RUN, on each clk with ce=1:
  - Compute {carry, acc_next} = acc + fcode_r, unsigned, ACC_W+1 bits. Register acc <= acc_next.
  - carry=1 marks the end of one period: ncnt <= ncnt+1, saturating at all-ones.
  - On a carry cycle, if (nper_r!=0 and ncnt+1==nper_r) or stop_req=1:
    - acc<=0, go to IDLE, done=1 for that cycle's next clock, busy<=0.
    - The output therefore always ends on a whole period with Ux low.
  - Cycles with ce=0: acc and ncnt hold; carry and stop handling are deferred.
- stop:
  - stop=1 in RUN sets stop_req. The run ends at the next carry, not immediately.
  - If stop and a terminating carry occur in the same cycle, the run ends once; a single done pulse.
- load while in RUN is ignored (no retune, err unchanged).
- ncnt holds its final value in IDLE until the next accepted load.
- Ux is taken directly from the acc register MSB: glitch-free, zero extra latency after acc.
- Duty cycle is 50% ±1 ce-cycle. Period in ce-cycles = 2^ACC_W/fcode (non-integer values dither).
- Continuous mode (nper=0): runs until stop. ncnt saturates at 2^CNT_W-1; acc wraps freely.

Test Plan:
- ACC_W=8, fcode=64, nper=3, ce=1, load pulse -> acc sequence 64,128,192,0 repeated; Ux 0,1,1,0 per period; ncnt increments on every 0; done pulse exactly 12 clocks after busy rises; ncnt=3; busy=0; Ux=0.
- ACC_W=8, fcode=96, nper=0, stop asserted at clock 5 -> run continues to the next carry (acc wraps at clock 8, 96*8=768=3*256); done at that boundary; ncnt=3.
- ce toggled 1,0,1,0 with fcode=64, nper=1 -> done after 8 clocks (4 enabled cycles); acc held on ce=0 cycles.
- load with fcode=0, then with fcode=128 (ACC_W=8) -> err=1, busy stays 0, no done. Then a valid load (fcode=32) -> err clears, busy=1.
- st pulsed mid-burst (fcode=64, nper=5, after 7 clocks) -> immediate Ux=0, busy=0, ncnt=0, no done. A load pulse afterwards restarts cleanly.
- Loopback into the meter: fcode=2^ACC_W/100 (Fce/100), gate Tm=1 s equivalent -> meter F reads Fce/100 ±1 count; X matches generator ncnt.
